// File: rtl/fc_pkg.sv
// Shared types and fixed-point helpers for the fully-connected layer sequencer.
// Q8.8 operands; the accumulator carries Q16.16 products until the final shift.
package fc_pkg;

    localparam int FRAC_BITS = 8;
    // Working width for the shift/saturate step; the accumulator must fit within it.
    localparam int SAT_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_BIAS,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Drops the extra fraction bits (arithmetic shift, rounds toward -inf) and
    // clamps to the signed range of a 'width'-bit word.
    function automatic logic signed [SAT_W-1:0] saturate_round(
        input logic signed [SAT_W-1:0] acc,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        shifted = acc >>> FRAC_BITS;
        max_v   = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        min_v   = ~max_v;
        if (shifted > max_v) begin
            return max_v;
        end
        if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate datapath for one output neuron: Q8.8 x Q8.8 products and a
// Q8.8 bias are summed at Q16.16, then shifted, saturated and optionally ReLU-clamped.
module fc_mac
    import fc_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int IN_SZ = 2,
    parameter int RELU  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_mac_en,
    input  logic                   i_bias_en,
    input  logic signed [SIZE-1:0] i_act,
    input  logic signed [SIZE-1:0] i_weight,
    output logic        [SIZE-1:0] o_result
);

    // Sized so IN_SZ full-scale products plus one bias can never wrap.
    localparam int ACC_W = 2 * SIZE + $clog2(IN_SZ + 1);

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [2*SIZE-1:0] w_prod;
    logic signed [SAT_W-1:0]  w_sat;
    logic signed [SIZE-1:0]   w_res;

    assign w_prod = i_act * i_weight;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_mac_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end else if (i_bias_en) begin
            r_acc <= r_acc + (ACC_W'(i_weight) <<< FRAC_BITS);
        end
    end

    assign w_sat    = saturate_round(SAT_W'(r_acc), SIZE);
    assign w_res    = SIZE'(w_sat);
    assign o_result = ((RELU != 0) && w_res[SIZE-1]) ? '0 : w_res;

endmodule

// File: rtl/fc_mac_sequencer.sv
// Walks a row-major weight/bias stream through one fully-connected layer and
// emits one write per output neuron, followed by a single-cycle done pulse.
module fc_mac_sequencer
    import fc_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int IN_SZ  = 2,
    parameter int OUT_SZ = 2,
    parameter int RELU   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [IN_SZ*SIZE-1:0]   in_values,
    input  logic                    w_valid,
    input  logic [SIZE-1:0]         w_data,
    output logic                    w_ready,
    output logic                    load_en,
    output logic [SIZE-1:0]         load_value,
    output logic [SIZE-1:0]         load_address,
    output logic                    busy,
    output logic                    done
);

    localparam int I_W = (IN_SZ > 1) ? $clog2(IN_SZ) : 1;
    localparam int J_W = (OUT_SZ > 1) ? $clog2(OUT_SZ) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(IN_SZ - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(OUT_SZ - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [I_W-1:0]  r_i;
    logic [J_W-1:0]  r_j;
    logic [SIZE-1:0] r_snap [IN_SZ];
    logic [SIZE-1:0] r_last_value;
    logic [SIZE-1:0] r_last_addr;
    logic            w_clear;
    logic            w_mac_en;
    logic            w_bias_en;
    logic [SIZE-1:0] w_result;
    logic [SIZE-1:0] w_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_mac_en     = 1'b0;
        w_bias_en    = 1'b0;
        w_ready      = 1'b0;
        load_en      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_mac_en = 1'b1;
                    if (r_i == I_LAST) begin
                        w_state_next = ST_BIAS;
                    end
                end
            end
            ST_BIAS: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_bias_en    = 1'b1;
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                load_en      = 1'b1;
                w_clear      = 1'b1;
                w_state_next = (r_j == J_LAST) ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i          <= '0;
            r_j          <= '0;
            r_last_value <= '0;
            r_last_addr  <= '0;
            // NOTE: the snapshot is plain flops (not a RAM), so it is cleared on reset like any other register.
            for (int k = 0; k < IN_SZ; k++) begin
                r_snap[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                        for (int k = 0; k < IN_SZ; k++) begin
                            r_snap[k] <= in_values[k*SIZE +: SIZE];
                        end
                    end
                end
                ST_MAC: begin
                    if (w_valid) begin
                        r_i <= (r_i == I_LAST) ? '0 : r_i + I_W'(1);
                    end
                end
                ST_WRITE: begin
                    r_last_value <= w_result;
                    r_last_addr  <= w_addr;
                    if (r_j != J_LAST) begin
                        r_j <= r_j + J_W'(1);
                        r_i <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_addr = SIZE'(r_j);

    // Outputs show the live result during WRITE and hold the last write otherwise.
    assign load_value   = (r_state == ST_WRITE) ? w_result : r_last_value;
    assign load_address = (r_state == ST_WRITE) ? w_addr   : r_last_addr;

    fc_mac #(
        .SIZE  (SIZE),
        .IN_SZ (IN_SZ),
        .RELU  (RELU)
    ) u_fc_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_mac_en  (w_mac_en),
        .i_bias_en (w_bias_en),
        .i_act     (r_snap[r_i]),
        .i_weight  (w_data),
        .o_result  (w_result)
    );

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Self-checking bench: a linear and a ReLU instance share stimulus; fixed vectors,
// reset/restart sequences and randomized runs are compared against a Q8.8 model.
module tb_fc_mac_sequencer;

    localparam int SIZE   = 16;
    localparam int IN_SZ  = 2;
    localparam int OUT_SZ = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [IN_SZ*SIZE-1:0] in_values;
    logic                  w_valid;
    logic [SIZE-1:0]       w_data;

    logic            w_ready_a, load_en_a, busy_a, done_a;
    logic [SIZE-1:0] load_value_a, load_address_a;
    logic            w_ready_b, load_en_b, busy_b, done_b;
    logic [SIZE-1:0] load_value_b, load_address_b;

    fc_mac_sequencer #(.SIZE(SIZE), .IN_SZ(IN_SZ), .OUT_SZ(OUT_SZ), .RELU(0)) u_dut_lin (
        .clk(clk), .rst_n(rst_n), .start(start), .in_values(in_values),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_a),
        .load_en(load_en_a), .load_value(load_value_a), .load_address(load_address_a),
        .busy(busy_a), .done(done_a)
    );

    fc_mac_sequencer #(.SIZE(SIZE), .IN_SZ(IN_SZ), .OUT_SZ(OUT_SZ), .RELU(1)) u_dut_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .in_values(in_values),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_b),
        .load_en(load_en_b), .load_value(load_value_b), .load_address(load_address_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          viol = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (load_en_a) wr_a.push_back({load_address_a, load_value_a});
        if (load_en_b) wr_b.push_back({load_address_b, load_value_b});
        if (done_a) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (w_ready_a && (!busy_a || load_en_a || done_a)) viol++;
        if (w_ready_b != w_ready_a || busy_b != busy_a || done_b != done_a || load_en_b != load_en_a) viol++;
    end

    typedef struct packed {
        logic [1:0][15:0] in_v;
        logic [5:0][15:0] stream;   // row-major: w00, w01, b0, w10, w11, b1 (index 0 first)
        logic [1:0][15:0] exp_lin;
        logic [1:0][15:0] exp_relu;
        logic [1:0]       stall;    // 0: always valid, 1: alternate cycles, 2: random
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Plain Q8.8 arithmetic: dot product plus bias at Q16.16, floor-shift, clamp.
    function automatic logic [15:0] ref_out(input logic [1:0][15:0] in_v,
                                            input logic [5:0][15:0] s,
                                            input int row, input bit relu);
        longint acc;
        logic [15:0] r;
        acc = 0;
        for (int i = 0; i < 2; i++)
            acc += longint'($signed(in_v[i])) * longint'($signed(s[row*3 + i]));
        acc += longint'($signed(s[row*3 + 2])) * 256;
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        r = 16'(acc);
        return r;
    endfunction

    function automatic logic [15:0] rnd_word();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return 16'($urandom_range(0, 1023)) - 16'd512;
    endfunction

    task automatic drive_run(input logic [1:0][15:0] in_v, input logic [5:0][15:0] stream,
                             input int stall_mode, input bit disturb, input int abort_at,
                             output int start_cyc, output int words);
        int  k;
        int  budget;
        bit  v;
        bit  xfer;
        @(negedge clk);
        in_values = in_v;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (disturb) in_values = ~in_v;
        k = 0;
        budget = 0;
        while (k < 6 && budget < 400) begin
            if (k == abort_at) break;
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 0;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            w_valid = v;
            w_data  = stream[k];
            start   = disturb && (k == 1);
            if (disturb && k == 3) in_values = {rnd_word(), rnd_word()};
            xfer = v && w_ready_a;
            @(negedge clk);
            if (xfer) k++;
            budget++;
        end
        w_valid = 1'b0;
        start   = 1'b0;
        words   = k;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input logic [1:0][15:0] exp_lin,
                                input logic [1:0][15:0] exp_relu);
        check({tag, " lin write count"}, wr_a.size(), 2);
        check({tag, " relu write count"}, wr_b.size(), 2);
        for (int r = 0; r < 2; r++) begin
            if (wr_a.size() > r) begin
                check($sformatf("%s lin addr%0d", tag, r), wr_a[r][31:16], r);
                check($sformatf("%s lin value%0d", tag, r), wr_a[r][15:0], exp_lin[r]);
            end
            if (wr_b.size() > r) begin
                check($sformatf("%s relu addr%0d", tag, r), wr_b[r][31:16], r);
                check($sformatf("%s relu value%0d", tag, r), wr_b[r][15:0], exp_relu[r]);
            end
        end
    endtask

    task automatic run_full(input string tag, input vec_t v, input bit disturb, input bit check_lat);
        int sc;
        int words;
        int d0;
        wr_a.delete();
        wr_b.delete();
        d0 = done_cnt;
        drive_run(v.in_v, v.stream, int'(v.stall), disturb, -1, sc, words);
        check({tag, " words accepted"}, words, 6);
        wait_done(d0);
        check({tag, " done pulses"}, done_cnt - d0, 1);
        if (check_lat) check({tag, " start-to-done cycles"}, done_cyc - sc, 9);
        check_writes(tag, v.exp_lin, v.exp_relu);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   sc;
        int   words;
        int   d0;

        tbl[0].in_v     = {16'h0200, 16'h0100};
        tbl[0].stream   = {16'h0100, 16'hFF00, 16'h0080, 16'h0000, 16'h0100, 16'h0100};
        tbl[0].exp_lin  = {16'hFF80, 16'h0300};
        tbl[0].exp_relu = {16'h0000, 16'h0300};
        tbl[0].stall    = 2'd0;

        tbl[1].in_v     = {16'h7F00, 16'h7F00};
        tbl[1].stream   = {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
        tbl[1].exp_lin  = {16'h7FFF, 16'h7FFF};
        tbl[1].exp_relu = {16'h7FFF, 16'h7FFF};
        tbl[1].stall    = 2'd0;

        tbl[2].in_v     = {16'h0000, 16'h7F00};
        tbl[2].stream   = {16'hFF00, 16'h0000, 16'h0100, 16'h8000, 16'h7F00, 16'h8100};
        tbl[2].exp_lin  = {16'h7E00, 16'h8000};
        tbl[2].exp_relu = {16'h7E00, 16'h0000};
        tbl[2].stall    = 2'd0;

        tbl[3]          = tbl[0];
        tbl[3].stall    = 2'd1;

        tbl[4].in_v     = {16'hFFFF, 16'h0001};
        tbl[4].stream   = {16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0080};
        tbl[4].exp_lin  = {16'hFFFF, 16'h0000};
        tbl[4].exp_relu = {16'h0000, 16'h0000};
        tbl[4].stall    = 2'd0;

        rst_n     = 1'b1;
        start     = 1'b0;
        w_valid   = 1'b0;
        w_data    = '0;
        in_values = '0;
        #2 rst_n = 1'b0;
        #2;
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset load_en", load_en_a, 0);
        check("reset w_ready", w_ready_a, 0);
        check("reset load_value", load_value_a, 0);
        check("reset load_address", load_address_a, 0);
        check("reset relu busy", busy_b, 0);
        check("reset relu load_value", load_value_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++)
            run_full($sformatf("vec%0d", v), tbl[v], 1'b0, tbl[v].stall == 2'd0);

        // Reset in the middle of row 1, then a clean restart.
        wr_a.delete();
        wr_b.delete();
        d0 = done_cnt;
        drive_run(tbl[0].in_v, tbl[0].stream, 0, 1'b0, 4, sc, words);
        check("abort words before reset", words, 4);
        check("abort row0 written before reset", wr_a.size(), 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_a, 0);
        check("abort load_en", load_en_a, 0);
        check("abort w_ready", w_ready_a, 0);
        check("abort load_value", load_value_a, 0);
        check("abort load_address", load_address_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("abort no later writes", wr_a.size(), 1);
        check("abort no done pulse", done_cnt - d0, 0);
        run_full("restart", tbl[0], 1'b0, 1'b1);

        // Spurious start and changing in_values during a run.
        run_full("disturb", tbl[0], 1'b1, 1'b0);

        for (int n = 0; n < 16; n++) begin
            rv.in_v   = {rnd_word(), rnd_word()};
            for (int w = 0; w < 6; w++) rv.stream[w] = rnd_word();
            for (int r = 0; r < 2; r++) begin
                rv.exp_lin[r]  = ref_out(rv.in_v, rv.stream, r, 1'b0);
                rv.exp_relu[r] = ref_out(rv.in_v, rv.stream, r, 1'b1);
            end
            rv.stall = 2'd2;
            run_full($sformatf("rand%0d", n), rv, 1'b0, 1'b0);
        end

        check("w_ready/busy protocol violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fc_mac_sequencer.md
FC_MAC_SEQUENCER -- requirements
Module: fc_mac_sequencer

Interface
REQ-001 Parameter SIZE, default 16: word width of activations, weights and biases (signed Q8.8).
REQ-002 Parameter IN_SZ, default 2: input-layer neuron count.
REQ-003 Parameter OUT_SZ, default 2: output-layer neuron count; the output layer is a Neuron_Layer of LAYER_SZ=OUT_SZ.
REQ-004 Parameter RELU, default 0: 1 clamps negative results to 0.
REQ-005 Fixed: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  begin one layer evaluation; sampled only in IDLE.
REQ-009 in_values  in  IN_SZ x SIZE  packed input-layer values, index 0 first (input-layer Neuron_Layer "values").
REQ-010 w_valid  in  1  weight-stream word valid.
REQ-011 w_data  in  SIZE  weight-stream word, signed Q8.8.
REQ-012 w_ready  out  1  sequencer accepts w_data this cycle.
REQ-013 load_en  out  1  write strobe to the output Neuron_Layer.
REQ-014 load_value  out  SIZE  result word.
REQ-015 load_address  out  SIZE  output neuron index.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the last write.

Function
REQ-018 FSM states SHALL be IDLE, MAC, BIAS, WRITE, DONE.
REQ-019 IDLE: on start=1, snapshot in_values into an internal register, clear accumulator, set row j=0 and column i=0, go to MAC; otherwise remain in IDLE.
REQ-020 The weight stream SHALL be row-major: for each row j, IN_SZ weights (i=0..IN_SZ-1), then one bias word.
REQ-021 w_ready SHALL be 1 in MAC and BIAS only; a word transfers when w_valid and w_ready are both 1.
REQ-022 MAC: on each transfer, acc += snapshot[i] * w_data (full 2*SIZE-bit signed product); i increments; after the transfer with i=IN_SZ-1, go to BIAS.
REQ-023 BIAS: on transfer, acc += w_data sign-extended and shifted left 8; go to WRITE.
REQ-024 If w_valid=0, the FSM SHALL hold state, i and acc unchanged (arbitrary stalls permitted).
REQ-025 Accumulator width SHALL be 2*SIZE+clog2(IN_SZ+1) bits; no internal overflow.
REQ-026 Result = acc arithmetic-shifted right 8, saturated to [0x8000, 0x7FFF], then clamped to 0 if RELU=1 and negative.
REQ-027 WRITE: for exactly one cycle, load_en=1, load_value=result, load_address=j; then if j=OUT_SZ-1 go to DONE, else j++, i=0, clear acc, go to MAC.
REQ-028 DONE: done=1 for one cycle, then go to IDLE.
REQ-029 load_en SHALL be 0 outside WRITE; load_value and load_address SHALL hold their last value when load_en=0.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 With w_valid held at 1, per-row latency SHALL be IN_SZ+2 cycles; done SHALL follow start by OUT_SZ*(IN_SZ+2)+1 cycles.
REQ-032 Changes to in_values after start SHALL NOT affect the current run.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE and busy, done, load_en, w_ready, load_value, load_address, acc, i, j and the snapshot to 0.
REQ-034 Reset during a run SHALL abort it with no further load_en; a subsequent start SHALL run from row 0.

Structure
REQ-035 Package fc_pkg SHALL hold FRAC_BITS=8, the state enum type and the saturate/round function.
REQ-036 Sub-module fc_mac SHALL contain the multiply, accumulator and saturation datapath; fc_mac_sequencer SHALL contain the FSM and counters.

Verification (IN_SZ=2, OUT_SZ=2 unless stated)
REQ-037 in=[0x0100,0x0200]; row0 w=[0x0100,0x0100] b=0x0000; row1 w=[0x0080,0xFF00] b=0x0100 -> writes (addr0, 0x0300) then (addr1, 0xFF80); done 9 cycles after start.
REQ-038 Same as REQ-037 with RELU=1 -> (addr1, 0x0000).
REQ-039 in=[0x7F00,0x7F00], w=[0x7F00,0x7F00], b=0x7F00 -> 0x7FFF; w=[0x8100,0x7F00] on in=[0x7F00,0x0000], b=0x8000 -> 0x8000.
REQ-040 REQ-037 stimulus with w_valid low on alternate cycles -> identical writes, exactly 2 load_en pulses, w_ready never asserted outside MAC/BIAS.
REQ-041 rst_n low during row1 MAC -> no further load_en, busy=0, done never pulses; a new start with REQ-037 data -> both correct writes.
REQ-042 start pulsed during MAC and in_values changed mid-run -> no restart; results match the snapshot taken at start.
